// File: rtl/led_pkg.sv
// Shared types and default timing for the WS2812 LED transmitter.
// Optional macro LED_GRB_REORDER_EN selects {G,R,B} transmit order.
package led_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_SEND  = 2'd2,
    ST_LATCH = 2'd3
  } led_state_e;

  localparam int LED_DATA_W       = 24;
  localparam int LED_NUM_DEF      = 128;
  localparam int LED_BIT_CYC_DEF  = 63;    // 1.25 us at 50 MHz
  localparam int LED_T0H_CYC_DEF  = 20;
  localparam int LED_T1H_CYC_DEF  = 40;
  localparam int LED_RST_CYC_DEF  = 14000;
  localparam int LED_UNDERRUN_DEF = 100;

  function automatic logic [23:0] grb_reorder(input logic [23:0] d);
    return {d[15:8], d[23:16], d[7:0]};
  endfunction

endpackage

// File: rtl/led_ws2812_tx_bit_timer.sv
// Phase counter for one WS2812 bit period; produces the line level and end-of-bit strobe.
module led_bit_timer #(
  parameter int BIT_CYC = led_pkg::LED_BIT_CYC_DEF,
  parameter int T0H_CYC = led_pkg::LED_T0H_CYC_DEF,
  parameter int T1H_CYC = led_pkg::LED_T1H_CYC_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic run,
  input  logic bit_val,
  output logic line,
  output logic bit_end
);

  localparam int PW = $clog2(BIT_CYC) + 1;
  localparam logic [PW-1:0] PH_LAST = PW'(BIT_CYC - 1);
  localparam logic [PW-1:0] T0H     = PW'(T0H_CYC);
  localparam logic [PW-1:0] T1H     = PW'(T1H_CYC);

  logic [PW-1:0] phase_q;
  logic [PW-1:0] phase_d;

  // Next phase: restart on a new word, wrap at the end of every bit, park at zero otherwise.
  always_comb begin
    phase_d = phase_q;
    if (start) begin
      phase_d = '0;
    end else if (run) begin
      if (phase_q == PH_LAST) begin
        phase_d = '0;
      end else begin
        phase_d = phase_q + PW'(1);
      end
    end else begin
      phase_d = '0;
    end
  end

  // Phase register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q <= '0;
    end else begin
      phase_q <= phase_d;
    end
  end

  // Line level and bit-end strobe from the current phase.
  always_comb begin
    bit_end = run && (phase_q == PH_LAST);
    line    = run && (phase_q < (bit_val ? T1H : T0H));
  end

endmodule

// File: rtl/led_ws2812_tx.sv
// WS2812 serialiser: pops colour words from the LED FIFO and drives the strip data pin.
// Build option LED_GRB_REORDER_EN transmits each word as {G,R,B} (DATA_W must be 24).
module led_ws2812_tx
  import led_pkg::*;
#(
  parameter int DATA_W       = LED_DATA_W,
  parameter int LED_NUM      = LED_NUM_DEF,
  parameter int BIT_CYC      = LED_BIT_CYC_DEF,
  parameter int T0H_CYC      = LED_T0H_CYC_DEF,
  parameter int T1H_CYC      = LED_T1H_CYC_DEF,
  parameter int RST_CYC      = LED_RST_CYC_DEF,
  parameter int UNDERRUN_CYC = LED_UNDERRUN_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              frame_start,
  input  logic              fifo_rd_vld,
  input  logic [DATA_W-1:0] fifo_rd_data,
  output logic              fifo_rd_en,
  output logic              led_dout,
  output logic              busy,
  output logic              frame_done,
  output logic              underrun
);

  localparam int LW = $clog2(LED_NUM) + 1;
  localparam int BW = $clog2(DATA_W) + 1;
  localparam int WW = $clog2(UNDERRUN_CYC) + 1;
  localparam int RW = $clog2(RST_CYC) + 1;

  localparam logic [LW-1:0] LED_LAST   = LW'(LED_NUM - 1);
  localparam logic [BW-1:0] BIT_FIRST  = BW'(DATA_W - 1);
  localparam logic [WW-1:0] WAIT_LAST  = WW'(UNDERRUN_CYC - 1);
  localparam logic [RW-1:0] LATCH_LAST = RW'(RST_CYC - 1);

  led_state_e        state_q, state_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic [BW-1:0]     bit_cnt_q, bit_cnt_d;
  logic [LW-1:0]     led_cnt_q, led_cnt_d;
  logic [WW-1:0]     wait_cnt_q, wait_cnt_d;
  logic [RW-1:0]     latch_cnt_q, latch_cnt_d;
  logic              busy_q, busy_d;
  logic              frame_done_q, frame_done_d;
  logic              underrun_q, underrun_d;

  logic pop_s;
  logic line_s;
  logic bit_end_s;
  logic word_end_s;

  assign pop_s      = (state_q == ST_FETCH) && fifo_rd_vld;
  assign word_end_s = bit_end_s && (bit_cnt_q == '0);

  led_bit_timer #(
    .BIT_CYC (BIT_CYC),
    .T0H_CYC (T0H_CYC),
    .T1H_CYC (T1H_CYC)
  ) u_bit_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (pop_s),
    .run     (state_q == ST_SEND),
    .bit_val (shreg_q[DATA_W-1]),
    .line    (line_s),
    .bit_end (bit_end_s)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (frame_start) state_d = ST_FETCH;
        else             state_d = ST_IDLE;
      end
      ST_FETCH: begin
        if (fifo_rd_vld)                  state_d = ST_SEND;
        else if (wait_cnt_q == WAIT_LAST) state_d = ST_LATCH;
        else                              state_d = ST_FETCH;
      end
      ST_SEND: begin
        if (word_end_s) state_d = (led_cnt_q == LED_LAST) ? ST_LATCH : ST_FETCH;
        else            state_d = ST_SEND;
      end
      ST_LATCH: begin
        if (latch_cnt_q == LATCH_LAST) state_d = ST_IDLE;
        else                           state_d = ST_LATCH;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Datapath next values: shift register, counters and status pulses.
  always_comb begin
    shreg_d      = shreg_q;
    bit_cnt_d    = bit_cnt_q;
    led_cnt_d    = led_cnt_q;
    wait_cnt_d   = wait_cnt_q;
    latch_cnt_d  = latch_cnt_q;
    busy_d       = busy_q;
    frame_done_d = 1'b0;
    underrun_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (frame_start) begin
          busy_d     = 1'b1;
          led_cnt_d  = '0;
          wait_cnt_d = '0;
        end else begin
          busy_d = busy_q;
        end
      end
      ST_FETCH: begin
        if (fifo_rd_vld) begin
`ifdef LED_GRB_REORDER_EN
          shreg_d = grb_reorder(fifo_rd_data);
`else
          shreg_d = fifo_rd_data;
`endif
          bit_cnt_d = BIT_FIRST;
        end else if (wait_cnt_q == WAIT_LAST) begin
          // Abandon the rest of the frame; remaining zones keep their old colour.
          underrun_d  = 1'b1;
          latch_cnt_d = '0;
        end else begin
          wait_cnt_d = wait_cnt_q + WW'(1);
        end
      end
      ST_SEND: begin
        if (bit_end_s) begin
          shreg_d = {shreg_q[DATA_W-2:0], 1'b0};
          if (bit_cnt_q == '0) begin
            led_cnt_d   = led_cnt_q + LW'(1);
            wait_cnt_d  = '0;
            latch_cnt_d = '0;
          end else begin
            bit_cnt_d = bit_cnt_q - BW'(1);
          end
        end else begin
          shreg_d = shreg_q;
        end
      end
      ST_LATCH: begin
        if (latch_cnt_q == LATCH_LAST) begin
          frame_done_d = 1'b1;
          busy_d       = 1'b0;
        end else begin
          latch_cnt_d = latch_cnt_q + RW'(1);
        end
      end
      default: begin
        busy_d = 1'b0;
      end
    endcase
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg_q      <= '0;
      bit_cnt_q    <= '0;
      led_cnt_q    <= '0;
      wait_cnt_q   <= '0;
      latch_cnt_q  <= '0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      underrun_q   <= 1'b0;
    end else begin
      shreg_q      <= shreg_d;
      bit_cnt_q    <= bit_cnt_d;
      led_cnt_q    <= led_cnt_d;
      wait_cnt_q   <= wait_cnt_d;
      latch_cnt_q  <= latch_cnt_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
      underrun_q   <= underrun_d;
    end
  end

  // Outputs; the line is forced low outside SEND so reset drops it at once.
  always_comb begin
    fifo_rd_en = pop_s;
    led_dout   = (state_q == ST_SEND) && line_s;
    busy       = busy_q;
    frame_done = frame_done_q;
    underrun   = underrun_q;
  end

endmodule

// File: tb/tb_led_ws2812_tx.sv
// Self-checking bench for led_ws2812_tx with shortened timing (6-clk bits, 2-word frames).
module tb_led_ws2812_tx;

  localparam int DW = 24;
  localparam int LN = 2;
  localparam int BC = 6;
  localparam int T0 = 2;
  localparam int T1 = 4;
  localparam int RC = 10;
  localparam int UC = 5;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          frame_start;
  logic          fifo_rd_vld;
  logic [DW-1:0] fifo_rd_data;
  logic          fifo_rd_en;
  logic          led_dout;
  logic          busy;
  logic          frame_done;
  logic          underrun;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  led_ws2812_tx #(
    .DATA_W(DW), .LED_NUM(LN), .BIT_CYC(BC), .T0H_CYC(T0), .T1H_CYC(T1),
    .RST_CYC(RC), .UNDERRUN_CYC(UC)
  ) dut (
    .clk(clk), .rst_n(rst_n), .frame_start(frame_start),
    .fifo_rd_vld(fifo_rd_vld), .fifo_rd_data(fifo_rd_data),
    .fifo_rd_en(fifo_rd_en), .led_dout(led_dout), .busy(busy),
    .frame_done(frame_done), .underrun(underrun)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Word as it should appear on the wire.
  function automatic logic [23:0] tx_word(input logic [23:0] d);
`ifdef LED_GRB_REORDER_EN
    return {d[15:8], d[23:16], d[7:0]};
`else
    return d;
`endif
  endfunction

  // One frame: nw words offered (word 1 withheld for st1 FETCH clocks), optional stray start at extra_k.
  task automatic run_frame(input string name, input int nw, input logic [23:0] w0,
                           input logic [23:0] w1, input int st1, input int extra_k);
    logic        exp_line[$];
    logic        line_tr[$];
    logic [23:0] q[$];
    logic [23:0] words[2];
    logic [23:0] rx[$];
    logic [23:0] t;
    logic [23:0] acc;
    int f1, und_idx, done_idx, total;
    int line_err, busy_err, pops, done_cnt, done_at, und_cnt, und_at;
    int run_len, nbits, bad;
    logic pop_now;
    logic exp_busy;

    words[0] = w0;
    words[1] = w1;
    for (int i = 0; i < nw; i++) q.push_back(words[i]);
    f1 = -1;
    und_idx = -1;
    exp_line.push_back(1'b0);
    for (int w = 0; w < nw; w++) begin
      if (w == 1) f1 = exp_line.size();
      for (int g = 0; g < ((w == 1) ? st1 + 1 : 1); g++) exp_line.push_back(1'b0);
      t = tx_word(words[w]);
      for (int b = 23; b >= 0; b--)
        for (int c = 0; c < BC; c++) exp_line.push_back(c < (t[b] ? T1 : T0));
    end
    if (nw < LN) begin
      for (int g = 0; g < UC; g++) exp_line.push_back(1'b0);
      und_idx = exp_line.size();
    end
    for (int g = 0; g < RC; g++) exp_line.push_back(1'b0);
    done_idx = exp_line.size();
    for (int g = 0; g < 3; g++) exp_line.push_back(1'b0);
    total = exp_line.size();

    line_err = 0; busy_err = 0; pops = 0; done_cnt = 0; done_at = -1; und_cnt = 0; und_at = -1;
    for (int k = 0; k < total; k++) begin
      @(negedge clk);
      frame_start = (k == 0) || (k == extra_k);
      fifo_rd_vld = (q.size() > 0) && !(f1 >= 0 && k >= f1 && k < f1 + st1);
      fifo_rd_data = fifo_rd_vld ? q[0] : 24'($urandom);
      #1;
      line_tr.push_back(led_dout);
      if (led_dout !== exp_line[k]) line_err++;
      exp_busy = (k >= 1) && (k < done_idx);
      if (busy !== exp_busy) busy_err++;
      if (frame_done === 1'b1) begin done_cnt++; done_at = k; end
      if (underrun === 1'b1) begin und_cnt++; und_at = k; end
      pop_now = fifo_rd_en && fifo_rd_vld;
      @(posedge clk);
      if (pop_now) begin
        pops++;
        void'(q.pop_front());
      end
    end
    frame_start = 1'b0;
    fifo_rd_vld = 1'b0;

    check({name, "/line_err"}, 32'(line_err), 32'd0);
    check({name, "/busy_err"}, 32'(busy_err), 32'd0);
    check({name, "/pops"}, 32'(pops), 32'(nw));
    check({name, "/done_cnt"}, 32'(done_cnt), 32'd1);
    check({name, "/done_at"}, 32'(done_at), 32'(done_idx));
    check({name, "/und_cnt"}, 32'(und_cnt), (nw < LN) ? 32'd1 : 32'd0);
    if (nw < LN) check({name, "/und_at"}, 32'(und_at), 32'(und_idx));
    else         check({name, "/und_at"}, 32'(und_at), 32'hFFFF_FFFF);

    // Decode the captured line by pulse width and compare whole words.
    run_len = 0; nbits = 0; bad = 0; acc = '0;
    for (int k = 0; k < total; k++) begin
      if (line_tr[k] === 1'b1) begin
        run_len++;
      end else if (run_len > 0) begin
        if (run_len != T1 && run_len != T0) bad++;
        acc = {acc[22:0], (run_len == T1)};
        nbits++;
        if (nbits % 24 == 0) rx.push_back(acc);
        run_len = 0;
      end
    end
    check({name, "/bad_pulse"}, 32'(bad), 32'd0);
    check({name, "/nbits"}, 32'(nbits), 32'(24 * nw));
    for (int w = 0; w < nw; w++)
      if (w < rx.size()) check({name, "/word"}, {8'h00, rx[w]}, {8'h00, tx_word(words[w])});
      else               check({name, "/word_missing"}, 32'(rx.size()), 32'(nw));
  endtask

  initial begin
    rst_n = 1'b0;
    frame_start = 1'b0;
    fifo_rd_vld = 1'b0;
    fifo_rd_data = '0;
    repeat (3) @(negedge clk);
    check("rst/led_dout", 32'(led_dout), 32'd0);
    check("rst/busy", 32'(busy), 32'd0);
    check("rst/rd_en", 32'(fifo_rd_en), 32'd0);
    check("rst/frame_done", 32'(frame_done), 32'd0);
    check("rst/underrun", 32'(underrun), 32'd0);
    rst_n = 1'b1;

    // Reset in the middle of the first bit of a word.
    @(negedge clk);
    frame_start = 1'b1;
    fifo_rd_vld = 1'b1;
    fifo_rd_data = 24'hFFFFFF;
    @(negedge clk);
    frame_start = 1'b0;
    #1;
    check("midrst/fetch_pop", 32'(fifo_rd_en), 32'd1);
    @(negedge clk);
    #1;
    check("midrst/line_high", 32'(led_dout), 32'd1);
    check("midrst/busy_high", 32'(busy), 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    check("midrst/led_dout", 32'(led_dout), 32'd0);
    check("midrst/busy", 32'(busy), 32'd0);
    check("midrst/rd_en", 32'(fifo_rd_en), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      #1;
      check("postrst/activity", {28'd0, led_dout, busy, frame_done | underrun, fifo_rd_en}, 32'd0);
    end
    fifo_rd_vld = 1'b0;

    run_frame("normal", 2, 24'hFF0000, 24'h0000AA, 0, -1);
    run_frame("underrun", 1, 24'($urandom), 24'h000000, 0, -1);
    run_frame("stall3", 2, 24'($urandom), 24'($urandom), 3, -1);
    run_frame("stall4", 2, 24'($urandom), 24'($urandom), UC - 1, -1);
    run_frame("busy_start", 2, 24'($urandom), 24'($urandom), 0, 60);
    run_frame("grb", 2, 24'h123456, 24'($urandom), 0, -1);
    for (int r = 0; r < 3; r++)
      run_frame("random", 2, 24'($urandom), 24'($urandom), int'($urandom_range(UC - 1, 0)), -1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
